// File: rtl/llm_int8_pkg.sv
// Shared types and helpers for the int8 low-magnitude quantization path.
package llm_int8_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SCALE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned QUANT_WIDTH = 8;

  // Largest magnitude a q-bit output may carry; the most negative code is never used.
  function automatic int sat_max(input int unsigned q);
    return (32'sd1 <<< (q - 32'd1)) - 32'sd1;
  endfunction

  function automatic int sat_min(input int unsigned q);
    return -sat_max(q);
  endfunction

  function automatic int unsigned bit_length(input logic [31:0] v);
    int unsigned len;
    len = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) begin
        len = 32'(i + 1);
      end else begin
        len = len;
      end
    end
    return len;
  endfunction

  function automatic int unsigned calc_shift(input logic [31:0] absmax, input int unsigned q);
    int unsigned len;
    len = bit_length(absmax);
    if (len > q - 32'd1) begin
      return len - (q - 32'd1);
    end else begin
      return 32'd0;
    end
  endfunction

endpackage

// File: rtl/llm_int8_round_sat.sv
// Round-half-up arithmetic right shift followed by symmetric saturation to Q bits.
module llm_int8_round_sat
  import llm_int8_pkg::*;
#(
  parameter int IN_WIDTH    = 16,
  parameter int Q           = 8,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic [IN_WIDTH-1:0]    x,
  input  logic [SHIFT_WIDTH-1:0] shift,
  output logic [Q-1:0]           y
);

  localparam logic signed [IN_WIDTH:0] HI_S = (IN_WIDTH+1)'(sat_max(Q));
  localparam logic signed [IN_WIDTH:0] LO_S = (IN_WIDTH+1)'(sat_min(Q));

  logic signed [IN_WIDTH:0] x_ext_s;
  logic signed [IN_WIDTH:0] bias_s;
  logic signed [IN_WIDTH:0] sum_s;
  logic signed [IN_WIDTH:0] r_s;

  // One extra bit keeps x + bias from wrapping for the largest positive input.
  always_comb begin
    x_ext_s = {x[IN_WIDTH-1], x};
    if (shift != '0) begin
      bias_s = (IN_WIDTH+1)'(1) << (shift - SHIFT_WIDTH'(1));
    end else begin
      bias_s = '0;
    end
    sum_s = x_ext_s + bias_s;
    r_s   = sum_s >>> shift;
    if (r_s > HI_S) begin
      y = HI_S[Q-1:0];
    end else if (r_s < LO_S) begin
      y = LO_S[Q-1:0];
    end else begin
      y = r_s[Q-1:0];
    end
  end

endmodule

// File: rtl/llm_int8_absmax_quantizer.sv
// Buffers one tile, finds its absolute maximum, then replays it as saturated
// Q-bit integers scaled by a power-of-two right shift.
module llm_int8_absmax_quantizer
  import llm_int8_pkg::*;
#(
  parameter int IN_WIDTH           = 16,
  parameter int IN_SIZE            = 4,
  parameter int IN_PARALLELISM     = 20,
  parameter int IN_DEPTH           = 3,
  parameter int QUANTIZATION_WIDTH = QUANT_WIDTH,
  parameter int SHIFT_WIDTH        = $clog2(IN_WIDTH) + 1
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [IN_PARALLELISM*IN_SIZE-1:0][IN_WIDTH-1:0]           data_in,
  input  logic                                                  data_in_valid,
  output logic                                                  data_in_ready,
  output logic [IN_PARALLELISM*IN_SIZE-1:0][QUANTIZATION_WIDTH-1:0] data_out,
  output logic [SHIFT_WIDTH-1:0]                                data_out_shift,
  output logic                                                  data_out_valid,
  input  logic                                                  data_out_ready
);

  localparam int N     = IN_PARALLELISM * IN_SIZE;
  localparam int CNT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int NP    = 1 << $clog2(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_DEPTH - 1);

  typedef logic [N-1:0][IN_WIDTH-1:0] beat_t;

  function automatic logic [IN_WIDTH-1:0] abs_val(input logic [IN_WIDTH-1:0] v);
    if (v[IN_WIDTH-1]) begin
      return ~v + IN_WIDTH'(1);
    end else begin
      return v;
    end
  endfunction

  // Pairwise comparator tree; leaves past N stay zero so they never win.
  function automatic logic [IN_WIDTH-1:0] beat_absmax(input beat_t beat);
    logic [IN_WIDTH-1:0] lvl [NP];
    for (int i = 0; i < NP; i++) lvl[i] = '0;
    for (int i = 0; i < N; i++) lvl[i] = abs_val(beat[i]);
    for (int step = 1; step < NP; step = step * 2) begin
      for (int i = 0; i + step < NP; i = i + 2 * step) begin
        if (lvl[i+step] > lvl[i]) begin
          lvl[i] = lvl[i+step];
        end else begin
          lvl[i] = lvl[i];
        end
      end
    end
    return lvl[0];
  endfunction

  state_e                  state_r, state_next_s;
  logic [CNT_W-1:0]        cnt_r, cnt_next_s;
  logic [IN_WIDTH-1:0]     absmax_r, absmax_next_s;
  logic [SHIFT_WIDTH-1:0]  shift_r, shift_next_s;
  beat_t                   buffer_r [IN_DEPTH];
  beat_t                   cur_beat_s;
  logic [IN_WIDTH-1:0]     beat_max_s;
  logic                    in_fire_s;
  logic [N-1:0][QUANTIZATION_WIDTH-1:0] quant_s;

  assign data_in_ready = (state_r == FILL) && !rst;
  assign in_fire_s     = data_in_valid && data_in_ready;
  assign beat_max_s    = beat_absmax(data_in);
  assign cur_beat_s    = buffer_r[cnt_r];

  // Next-state, counter, running absmax and scale selection.
  always_comb begin
    state_next_s  = state_r;
    cnt_next_s    = cnt_r;
    absmax_next_s = absmax_r;
    shift_next_s  = shift_r;
    case (state_r)
      FILL: begin
        if (in_fire_s) begin
          absmax_next_s = (beat_max_s > absmax_r) ? beat_max_s : absmax_r;
          if (cnt_r == LAST) begin
            state_next_s = SCALE;
          end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_next_s = cnt_r;
        end
      end
      SCALE: begin
        shift_next_s = SHIFT_WIDTH'(calc_shift(32'(absmax_r), QUANTIZATION_WIDTH));
        cnt_next_s   = '0;
        state_next_s = DRAIN;
      end
      DRAIN: begin
        if (data_out_ready) begin
          if (cnt_r == LAST) begin
            state_next_s  = FILL;
            cnt_next_s    = '0;
            absmax_next_s = '0;
            shift_next_s  = '0;
          end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_next_s = cnt_r;
        end
      end
      default: begin
        state_next_s  = FILL;
        cnt_next_s    = '0;
        absmax_next_s = '0;
        shift_next_s  = '0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= FILL;
      cnt_r    <= '0;
      absmax_r <= '0;
      shift_r  <= '0;
    end else begin
      state_r  <= state_next_s;
      cnt_r    <= cnt_next_s;
      absmax_r <= absmax_next_s;
      shift_r  <= shift_next_s;
    end
  end

  // Tile storage; contents are only read after a full tile has been written.
  always_ff @(posedge clk) begin
    if (in_fire_s) begin
      buffer_r[cnt_r] <= data_in;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_rs
    llm_int8_round_sat #(
      .IN_WIDTH    (IN_WIDTH),
      .Q           (QUANTIZATION_WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_rs (
      .x     (cur_beat_s[g]),
      .shift (shift_r),
      .y     (quant_s[g])
    );
  end

  // Outputs are forced to zero whenever no beat is being presented.
  always_comb begin
    data_out_valid = (state_r == DRAIN);
    if (state_r == DRAIN) begin
      data_out       = quant_s;
      data_out_shift = shift_r;
    end else begin
      data_out       = '0;
      data_out_shift = '0;
    end
  end

endmodule

// File: tb/tb_llm_int8_absmax_quantizer.sv
// Directed bench for the absmax int8 quantizer: rounding, saturation, scaling,
// backpressure and mid-tile reset.
module tb_llm_int8_absmax_quantizer;

  localparam int N = 80;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N-1:0][15:0]   data_in = '0;
  logic                 data_in_valid = 1'b0;
  logic                 data_in_ready;
  logic [N-1:0][7:0]    data_out;
  logic [4:0]           data_out_shift;
  logic                 data_out_valid;
  logic                 data_out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [N-1:0][15:0] tile_v [3];
  logic [N-1:0][7:0]  out_v [3];
  int                 sh_v [3];

  llm_int8_absmax_quantizer dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_shift (data_out_shift),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int el(input int b, input int i);
    return int'($signed(out_v[b][i]));
  endfunction

  task automatic clear_tile();
    for (int b = 0; b < 3; b++) tile_v[b] = '0;
  endtask

  task automatic set_el(input int b, input int i, input int v);
    tile_v[b][i] = 16'(v);
  endtask

  task automatic send_beat(input logic [N-1:0][15:0] b);
    int g;
    g = 0;
    data_in = b;
    data_in_valid = 1'b1;
    while (data_in_ready !== 1'b1 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 100) chk("in_timeout", 0, 1);
    @(posedge clk); #1;
    data_in_valid = 1'b0;
  endtask

  task automatic send_tile();
    for (int b = 0; b < 3; b++) send_beat(tile_v[b]);
    chk("scale_valid_low", int'(data_out_valid), 0);
    chk("scale_ready_low", int'(data_in_ready), 0);
    @(posedge clk); #1;
    chk("drain_valid_high", int'(data_out_valid), 1);
  endtask

  task automatic recv_beat(input int j);
    int g;
    g = 0;
    while (data_out_valid !== 1'b1 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 100) chk("out_timeout", 0, 1);
    out_v[j] = data_out;
    sh_v[j]  = int'(data_out_shift);
    data_out_ready = 1'b1;
    @(posedge clk); #1;
    data_out_ready = 1'b0;
  endtask

  task automatic recv_rest(input int first);
    for (int j = first; j < 3; j++) recv_beat(j);
    chk("tile_done_valid", int'(data_out_valid), 0);
    chk("idle_shift", int'(data_out_shift), 0);
    chk("idle_data", int'(data_out[0]), 0);
    chk("idle_ready", int'(data_in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(data_in_ready), 0);
    chk("rst_valid", int'(data_out_valid), 0);
    chk("rst_shift", int'(data_out_shift), 0);
    chk("rst_data", int'(data_out[0]), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", int'(data_in_ready), 1);

    // Basic rounding, sign symmetry, plus a 5-cycle stall with input pressure.
    clear_tile();
    set_el(0, 0, 1000); set_el(0, 1, -1000); set_el(0, 79, 8);
    set_el(1, 5, 4);    set_el(1, 79, 16);
    set_el(2, 79, 3);   set_el(2, 10, -4);   set_el(2, 78, 24);
    send_tile();
    recv_beat(0);
    data_in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("stall_data", int'($signed(data_out[79])), 2);
      chk("stall_shift", int'(data_out_shift), 3);
      chk("stall_valid", int'(data_out_valid), 1);
      chk("stall_in_ready", int'(data_in_ready), 0);
    end
    data_in_valid = 1'b0;
    recv_rest(1);
    chk("t1_shift0", sh_v[0], 3);
    chk("t1_shift2", sh_v[2], 3);
    chk("t1_pos1000", el(0, 0), 125);
    chk("t1_neg1000", el(0, 1), -125);
    chk("t1_zero", el(0, 2), 0);
    chk("t1_b0_mark", el(0, 79), 1);
    chk("t1_four", el(1, 5), 1);
    chk("t1_b1_mark", el(1, 79), 2);
    chk("t1_three", el(2, 79), 0);
    chk("t1_neg4", el(2, 10), 0);
    chk("t1_b2_mark", el(2, 78), 3);

    // Saturation.
    clear_tile();
    set_el(0, 0, 1020); set_el(1, 3, -1020); set_el(2, 0, 12);
    send_tile();
    recv_rest(0);
    chk("t2_shift", sh_v[1], 3);
    chk("t2_sat_pos", el(0, 0), 127);
    chk("t2_sat_neg", el(1, 3), -127);
    chk("t2_twelve", el(2, 0), 2);

    // No scaling: outputs equal inputs.
    clear_tile();
    set_el(0, 0, 100); set_el(0, 1, -100); set_el(1, 2, 55); set_el(2, 7, -37);
    send_tile();
    recv_rest(0);
    chk("t3_shift", sh_v[0], 0);
    chk("t3_p100", el(0, 0), 100);
    chk("t3_m100", el(0, 1), -100);
    chk("t3_p55", el(1, 2), 55);
    chk("t3_m37", el(2, 7), -37);

    // All-zero tile.
    clear_tile();
    send_tile();
    recv_rest(0);
    chk("t3z_shift", sh_v[2], 0);
    chk("t3z_first", el(0, 0), 0);
    chk("t3z_last", el(2, 79), 0);

    // Extreme input.
    clear_tile();
    set_el(0, 0, 1000); set_el(1, 0, -32768); set_el(1, 1, -256);
    set_el(1, 2, -257); set_el(2, 1, 32767);
    send_tile();
    recv_rest(0);
    chk("t4_shift", sh_v[0], 9);
    chk("t4_1000", el(0, 0), 2);
    chk("t4_min", el(1, 0), -64);
    chk("t4_m256", el(1, 1), 0);
    chk("t4_m257", el(1, 2), -1);
    chk("t4_max", el(2, 1), 64);

    // Reset after two beats of a large tile; the next tile stands alone.
    clear_tile();
    set_el(0, 0, 30000); set_el(1, 0, -30000);
    send_beat(tile_v[0]);
    send_beat(tile_v[1]);
    rst = 1'b1;
    #2;
    chk("mid_rst_ready", int'(data_in_ready), 0);
    chk("mid_rst_valid", int'(data_out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_ready_after", int'(data_in_ready), 1);
    clear_tile();
    set_el(0, 0, 1000); set_el(2, 5, -9);
    send_tile();
    recv_rest(0);
    chk("t5_shift", sh_v[0], 3);
    chk("t5_1000", el(0, 0), 125);
    chk("t5_m9", el(2, 5), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
